// File: rtl/ca_pkg.sv
// rtl/ca_pkg.sv - shared types, row width and next-generation function for the CA engine
package ca_pkg;

  localparam int NCELL = 16;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} ca_state_t;

  // Elementary CA step: cell i takes rule[{L,C,R}] with L=cells[i+1], R=cells[i-1].
  // The row is padded by one cell each side so every neighbourhood is a plain 3-bit slice.
  function automatic logic [NCELL-1:0] next_row(input logic [NCELL-1:0] row,
                                                input logic [7:0]       rule,
                                                input logic             wrap);
    logic [NCELL+1:0] ext;
    logic [NCELL-1:0] nxt;
    ext = {wrap & row[0], row, wrap & row[NCELL-1]};
    nxt = '0;
    for (int i = 0; i < NCELL; i++) begin
      nxt[i] = rule[ext[i +: 3]];
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ca_evolve_if.sv
// rtl/ca_evolve_if.sv - control and display bus between the seed-loader side and the CA engine
interface ca_evolve_if
  import ca_pkg::*;
#(
  parameter int GEN_W = 8
);
  logic             start;
  logic             auto_run;
  logic             step;
  logic [7:0]       rule;
  logic             wrap;
  logic [GEN_W-1:0] max_gen;
  logic [3:0]       seed3;
  logic [3:0]       seed2;
  logic [3:0]       seed1;
  logic [3:0]       seed0;
  logic [NCELL-1:0] cells;
  logic [GEN_W-1:0] gen_count;
  logic             busy;
  logic             done;

  modport master (
    output start, auto_run, step, rule, wrap, max_gen, seed3, seed2, seed1, seed0,
    input  cells, gen_count, busy, done
  );

  modport slave (
    input  start, auto_run, step, rule, wrap, max_gen, seed3, seed2, seed1, seed0,
    output cells, gen_count, busy, done
  );
endinterface

// File: rtl/ca_next_gen.sv
// rtl/ca_next_gen.sv - combinational next-row computation for the CA engine
module ca_next_gen
  import ca_pkg::*;
(
  input  logic [NCELL-1:0] row,
  input  logic [7:0]       rule,
  input  logic             wrap,
  output logic [NCELL-1:0] nxt
);

  // Pure lookup of each cell's 3-cell neighbourhood in the rule byte
  always_comb begin
    nxt = next_row(row, rule, wrap);
  end

endmodule

// File: rtl/ca_evolve.sv
// rtl/ca_evolve.sv - 1-D elementary cellular-automaton engine with auto/manual advance
module ca_evolve
  import ca_pkg::*;
#(
  parameter int GEN_W    = 8,
  parameter int TICK_DIV = 25_000_000
)(
  input  logic              clk,
  input  logic              reset,
  ca_evolve_if.slave        bus
);

  localparam int             PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  PRE_LAST  = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]  PRE_ONE   = PW'(1);
  localparam logic [GEN_W-1:0] GEN_ONE = GEN_W'(1);

  ca_state_t        state;
  logic [NCELL-1:0] cells_q;
  logic [NCELL-1:0] cells_nxt;
  logic [GEN_W-1:0] gen_q;
  logic [GEN_W-1:0] max_gen_q;
  logic [7:0]       rule_q;
  logic             wrap_q;
  logic [PW-1:0]    pre_q;
  logic             step_d;
  logic             busy_q;
  logic             done_q;
  logic             tick;
  logic             step_rise;
  logic             adv;

  ca_next_gen u_next (
    .row  (cells_q),
    .rule (rule_q),
    .wrap (wrap_q),
    .nxt  (cells_nxt)
  );

  // Advance request: prescaler tick (auto mode) or manual step edge, merged into one advance
  always_comb begin
    tick      = (pre_q == PRE_LAST);
    step_rise = bus.step & ~step_d;
    adv       = (state == S_RUN) & ((bus.auto_run & tick) | step_rise);
  end

  // FSM, latches, prescaler and row register; all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      cells_q   <= '0;
      gen_q     <= '0;
      max_gen_q <= '0;
      rule_q    <= '0;
      wrap_q    <= 1'b0;
      pre_q     <= '0;
      step_d    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      step_d <= bus.step;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state     <= S_RUN;
            cells_q   <= {bus.seed3, bus.seed2, bus.seed1, bus.seed0};
            gen_q     <= '0;
            rule_q    <= bus.rule;
            wrap_q    <= bus.wrap;
            max_gen_q <= bus.max_gen;
            pre_q     <= '0;
            busy_q    <= 1'b1;
            done_q    <= 1'b0;
          end
        end
        S_RUN: begin
          if (gen_q == max_gen_q) begin
            // Target reached: stop without evolving, even if an advance is pending
            state  <= S_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            if (bus.auto_run) begin
              pre_q <= tick ? '0 : pre_q + PRE_ONE;
            end
            if (adv) begin
              cells_q <= cells_nxt;
              gen_q   <= gen_q + GEN_ONE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.cells     = cells_q;
  assign bus.gen_count = gen_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_ca_evolve.sv
// tb/tb_ca_evolve.sv - directed self-checking bench for ca_evolve
module tb_ca_evolve;
  import ca_pkg::*;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  ca_evolve_if #(.GEN_W(8)) bus ();

  ca_evolve #(.GEN_W(8), .TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic load(input logic [15:0] seed, input logic [7:0] rule, input logic wrap,
                      input logic [7:0] maxg, input logic ar);
    {bus.seed3, bus.seed2, bus.seed1, bus.seed0} = seed;
    bus.rule     = rule;
    bus.wrap     = wrap;
    bus.max_gen  = maxg;
    bus.auto_run = ar;
    bus.start    = 1'b1;
    edge1();
    bus.start    = 1'b0;
  endtask

  task automatic pulse_step();
    bus.step = 1'b1;
    edge1();
    bus.step = 1'b0;
    edge1();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    edge1();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    chk16("reset_cells", bus.cells, 16'h0000);
    chk8 ("reset_gen", bus.gen_count, 8'd0);
    chk1 ("reset_busy", bus.busy, 1'b0);
    chk1 ("reset_done", bus.done, 1'b0);
  endtask

  task automatic test_rule90_steps();
    load(16'h0080, 8'd90, 1'b1, 8'd5, 1'b0);
    chk16("t1_load_cells", bus.cells, 16'h0080);
    chk8 ("t1_load_gen", bus.gen_count, 8'd0);
    chk1 ("t1_load_busy", bus.busy, 1'b1);
    pulse_step();
    chk16("t1_step1_cells", bus.cells, 16'h0140);
    chk8 ("t1_step1_gen", bus.gen_count, 8'd1);
    pulse_step();
    chk16("t1_step2_cells", bus.cells, 16'h0220);
    chk8 ("t1_step2_gen", bus.gen_count, 8'd2);
    chk1 ("t1_step2_busy", bus.busy, 1'b1);
    do_reset();
  endtask

  task automatic test_wrap();
    load(16'h0001, 8'd90, 1'b1, 8'd1, 1'b0);
    pulse_step();
    chk16("t2_wrap_cells", bus.cells, 16'h8002);
    chk1 ("t2_wrap_done", bus.done, 1'b1);
    load(16'h0001, 8'd90, 1'b0, 8'd1, 1'b0);
    chk1 ("t2_reload_busy", bus.busy, 1'b1);
    chk8 ("t2_reload_gen", bus.gen_count, 8'd0);
    pulse_step();
    chk16("t2_nowrap_cells", bus.cells, 16'h0002);
    do_reset();
  endtask

  task automatic test_auto();
    load(16'h1234, 8'd204, 1'b0, 8'd3, 1'b1);
    repeat (3) edge1();
    chk8 ("t3_edge3_gen", bus.gen_count, 8'd0);
    edge1();
    chk8 ("t3_edge4_gen", bus.gen_count, 8'd1);
    repeat (3) edge1();
    chk8 ("t3_edge7_gen", bus.gen_count, 8'd1);
    edge1();
    chk8 ("t3_edge8_gen", bus.gen_count, 8'd2);
    repeat (4) edge1();
    chk8 ("t3_edge12_gen", bus.gen_count, 8'd3);
    chk1 ("t3_edge12_busy", bus.busy, 1'b1);
    edge1();
    chk1 ("t3_done", bus.done, 1'b1);
    chk1 ("t3_busy", bus.busy, 1'b0);
    chk16("t3_cells", bus.cells, 16'h1234);
    repeat (5) edge1();
    chk8 ("t3_gen_held", bus.gen_count, 8'd3);
    bus.auto_run = 1'b0;
    do_reset();
  endtask

  task automatic test_max_gen_zero();
    load(16'hBEEF, 8'd90, 1'b1, 8'd0, 1'b0);
    chk1 ("t4_load_busy", bus.busy, 1'b1);
    chk1 ("t4_load_done", bus.done, 1'b0);
    edge1();
    chk1 ("t4_done", bus.done, 1'b1);
    chk16("t4_cells", bus.cells, 16'hBEEF);
    chk8 ("t4_gen", bus.gen_count, 8'd0);
    load(16'hBEEF, 8'd0, 1'b1, 8'd1, 1'b0);
    pulse_step();
    chk16("t4_rule0_cells", bus.cells, 16'h0000);
    do_reset();
  endtask

  task automatic test_back_to_back();
    load(16'hA5A5, 8'd204, 1'b0, 8'd20, 1'b0);
    bus.step = 1'b1;
    repeat (10) edge1();
    bus.step = 1'b0;
    edge1();
    chk8 ("t5_held_step_gen", bus.gen_count, 8'd1);
    do_reset();
    load(16'hA5A5, 8'd204, 1'b0, 8'd20, 1'b1);
    repeat (3) edge1();
    bus.step = 1'b1;
    edge1();
    bus.step = 1'b0;
    bus.auto_run = 1'b0;
    chk8 ("t5_tick_and_step_gen", bus.gen_count, 8'd1);
    {bus.seed3, bus.seed2, bus.seed1, bus.seed0} = 16'hFFFF;
    bus.start = 1'b1;
    edge1();
    bus.start = 1'b0;
    edge1();
    chk16("t5_start_in_run_cells", bus.cells, 16'hA5A5);
    chk8 ("t5_start_in_run_gen", bus.gen_count, 8'd1);
    chk1 ("t5_start_in_run_busy", bus.busy, 1'b1);
    do_reset();
  endtask

  task automatic test_reset_mid_run();
    load(16'h0080, 8'd90, 1'b1, 8'd5, 1'b0);
    pulse_step();
    pulse_step();
    chk8 ("t6_pre_gen", bus.gen_count, 8'd2);
    do_reset();
    chk16("t6_cells", bus.cells, 16'h0000);
    chk8 ("t6_gen", bus.gen_count, 8'd0);
    chk1 ("t6_busy", bus.busy, 1'b0);
    chk1 ("t6_done", bus.done, 1'b0);
    repeat (2) edge1();
    chk1 ("t6_idle_busy", bus.busy, 1'b0);
    load(16'h0001, 8'd90, 1'b1, 8'd5, 1'b0);
    chk16("t6_reload_cells", bus.cells, 16'h0001);
    chk1 ("t6_reload_busy", bus.busy, 1'b1);
    pulse_step();
    chk16("t6_reload_step", bus.cells, 16'h8002);
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.auto_run = 1'b0;
    bus.step     = 1'b0;
    bus.rule     = 8'd0;
    bus.wrap     = 1'b0;
    bus.max_gen  = 8'd0;
    bus.seed3    = 4'd0;
    bus.seed2    = 4'd0;
    bus.seed1    = 4'd0;
    bus.seed0    = 4'd0;
    edge1();
    test_reset();
    test_rule90_steps();
    test_wrap();
    test_auto();
    test_max_gen_zero();
    test_back_to_back();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
